// File: rtl/acondicionador_condiciones_pkg.sv
// Shared timer state encoding, default timing constants and input bit positions.
// ACOND_DEBOUNCE_EN (see antirrebote) does not affect anything defined here.
package acond_pkg;

   typedef enum logic [1:0] {
      TMR_IDLE = 2'd0,
      TMR_RUN  = 2'd1,
      TMR_DONE = 2'd2
   } tmr_state_t;

   localparam int DEB_CYCLES_DEF = 16;
   localparam int TMR_LOAD_A_DEF = 1000;
   localparam int TMR_LOAD_B_DEF = 4000;

   localparam int NUM_IN       = 5;
   localparam int IDX_COIN     = 0;
   localparam int IDX_COFFEE   = 1;
   localparam int IDX_MILK     = 2;
   localparam int IDX_CANCEL   = 3;
   localparam int IDX_WATER    = 4;
   localparam int IDX_TMR_DONE = 5;

endpackage

// File: rtl/acondicionador_condiciones_antirrebote.sv
// Two-flop synchronizer plus optional debouncer (ACOND_DEBOUNCE_EN) for one raw input.
// deb is registered; rise is high in the cycle whose closing edge takes deb from 0 to 1.
module antirrebote #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic deb,
   output logic rise
);

   logic sync_1;
   logic sync_2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
      end
   end

`ifdef ACOND_DEBOUNCE_EN
   logic [7:0] cnt;
   logic       deb_q;
   logic       last;

   // The counter only runs while sync and deb disagree, so any bounce restarts qualification.
   assign last = (sync_2 != deb_q) && (cnt == 8'(DEB_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= 8'd0;
         deb_q <= 1'b0;
      end else if (sync_2 == deb_q) begin
         cnt <= 8'd0;
      end else if (last) begin
         cnt   <= 8'd0;
         deb_q <= sync_2;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

   assign deb  = deb_q;
   assign rise = last & sync_2;
`else
   assign deb  = sync_2;
   assign rise = sync_1 & ~sync_2;
`endif

endmodule

// File: rtl/acondicionador_condiciones.sv
// Conditions the five raw inputs and a one-shot timer into the controller condition bits.
// Build with ACOND_DEBOUNCE_EN to insert debouncers; without it inputs only pass the synchronizer.
module acondicionador_condiciones
   import acond_pkg::*;
#(
   parameter int         DEB_CYCLES  = DEB_CYCLES_DEF,
   parameter logic [4:0] STICKY_MASK = 5'b00111,
   parameter int         TMR_WIDTH   = 16,
   parameter int         TMR_LOAD_A  = TMR_LOAD_A_DEF,
   parameter int         TMR_LOAD_B  = TMR_LOAD_B_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] raw_in,
   input  logic [4:0] clr,
   input  logic       tmr_start,
   input  logic       tmr_sel,
   output logic [5:0] cond,
   output logic       tmr_busy
);

   localparam logic [TMR_WIDTH-1:0] LOAD_A = (TMR_LOAD_A == 0) ? TMR_WIDTH'(1) : TMR_WIDTH'(TMR_LOAD_A);
   localparam logic [TMR_WIDTH-1:0] LOAD_B = (TMR_LOAD_B == 0) ? TMR_WIDTH'(1) : TMR_WIDTH'(TMR_LOAD_B);

   logic [NUM_IN-1:0] deb;
   logic [NUM_IN-1:0] rise;
   logic [NUM_IN-1:0] cond_in;

   for (genvar i = 0; i < NUM_IN; i++) begin : g_in
      antirrebote #(
         .DEB_CYCLES(DEB_CYCLES)
      ) u_antirrebote (
         .clk  (clk),
         .rst  (rst),
         .raw  (raw_in[i]),
         .deb  (deb[i]),
         .rise (rise[i])
      );

      if (STICKY_MASK[i]) begin : g_sticky
         logic flag;
         // A new event on the same edge as clr wins, so no event is ever lost.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               flag <= 1'b0;
            end else begin
               flag <= rise[i] | (flag & ~clr[i]);
            end
         end
         assign cond_in[i] = flag;
      end else begin : g_level
         assign cond_in[i] = deb[i];
      end
   end

   tmr_state_t           state;
   tmr_state_t           state_nxt;
   logic [TMR_WIDTH-1:0] tmr_cnt;
   logic                 start_q;
   logic                 start_rise;
   logic                 tmr_done;

   assign start_rise = tmr_start & ~start_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= TMR_IDLE;
         start_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         start_q <= tmr_start;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmr_cnt <= '0;
      end else if (state == TMR_IDLE && start_rise) begin
         tmr_cnt <= tmr_sel ? LOAD_B : LOAD_A;
      end else if (state == TMR_RUN) begin
         tmr_cnt <= tmr_cnt - TMR_WIDTH'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         TMR_IDLE: if (start_rise) state_nxt = TMR_RUN;
         TMR_RUN: begin
            if (!tmr_start) begin
               state_nxt = TMR_IDLE;
            end else if (tmr_cnt == TMR_WIDTH'(1)) begin
               state_nxt = TMR_DONE;
            end
         end
         TMR_DONE: if (!tmr_start) state_nxt = TMR_IDLE;
         default:  state_nxt = TMR_IDLE;
      endcase
   end

   always_comb begin
      tmr_busy = 1'b0;
      tmr_done = 1'b0;
      case (state)
         TMR_RUN:  tmr_busy = 1'b1;
         TMR_DONE: tmr_done = 1'b1;
         default: begin
            tmr_busy = 1'b0;
            tmr_done = 1'b0;
         end
      endcase
   end

   assign cond = {tmr_done, cond_in};

endmodule

// File: tb/tb_acondicionador_condiciones.sv
// Directed bench for acondicionador_condiciones with DEB_CYCLES=4, loads 10/20.
// Expected latencies follow whether ACOND_DEBOUNCE_EN is defined for the build.
module tb_acondicionador_condiciones;

`ifdef ACOND_DEBOUNCE_EN
   localparam int LAT   = 6;
   localparam bit DEBEN = 1'b1;
`else
   localparam int LAT   = 2;
   localparam bit DEBEN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] raw_in = '0;
   logic [4:0] clr = '0;
   logic       tmr_start = 1'b0;
   logic       tmr_sel = 1'b0;
   logic [5:0] cond;
   logic       tmr_busy;

   int checks = 0;
   int passed = 0;

   acondicionador_condiciones #(
      .DEB_CYCLES  (4),
      .STICKY_MASK (5'b00111),
      .TMR_WIDTH   (16),
      .TMR_LOAD_A  (10),
      .TMR_LOAD_B  (20)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .raw_in    (raw_in),
      .clr       (clr),
      .tmr_start (tmr_start),
      .tmr_sel   (tmr_sel),
      .cond      (cond),
      .tmr_busy  (tmr_busy)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      tick(2);
      checks++;
      if (cond !== 6'b0) $display("FAIL reset_cond: got %b want 000000", cond);
      else passed++;
      checks++;
      if (tmr_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", tmr_busy);
      else passed++;
      rst = 1'b1;
      tick(1);
   endtask

   task automatic test_level();
      raw_in[3] = 1'b1;
      for (int k = 1; k <= LAT; k++) begin
         tick(1);
         checks++;
         if (cond[3] !== (k >= LAT)) $display("FAIL level_rise edge %0d: got %b want %b", k, cond[3], k >= LAT);
         else passed++;
      end
      raw_in[3] = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         tick(1);
         checks++;
         if (cond[3] !== (k < LAT)) $display("FAIL level_fall edge %0d: got %b want %b", k, cond[3], k < LAT);
         else passed++;
      end
      clr[3] = 1'b1;
      raw_in[3] = 1'b1;
      tick(LAT);
      checks++;
      if (cond[3] !== 1'b1) $display("FAIL level_ignores_clr: got %b want 1", cond[3]);
      else passed++;
      clr[3] = 1'b0;
      raw_in[3] = 1'b0;
      tick(LAT + 1);
   endtask

   task automatic test_glitch();
      raw_in[0] = 1'b1;
      tick(3);
      raw_in[0] = 1'b0;
      tick(10);
      checks++;
      if (cond[0] !== !DEBEN) $display("FAIL short_pulse: got %b want %b", cond[0], !DEBEN);
      else passed++;
      clr[0] = 1'b1;
      tick(1);
      clr[0] = 1'b0;
      checks++;
      if (cond[0] !== 1'b0) $display("FAIL short_pulse_clr: got %b want 0", cond[0]);
      else passed++;
      raw_in[0] = 1'b1;
      tick(8);
      raw_in[0] = 1'b0;
      tick(12);
      checks++;
      if (cond[0] !== 1'b1) $display("FAIL long_pulse_sticky: got %b want 1", cond[0]);
      else passed++;
      clr[0] = 1'b1;
      tick(1);
      clr[0] = 1'b0;
      checks++;
      if (cond[0] !== 1'b0) $display("FAIL long_pulse_clr: got %b want 0", cond[0]);
      else passed++;
   endtask

   task automatic test_clr_collision();
      raw_in[1] = 1'b1;
      tick(LAT - 1);
      checks++;
      if (cond[1] !== 1'b0) $display("FAIL collide_before: got %b want 0", cond[1]);
      else passed++;
      clr[1] = 1'b1;
      tick(1);
      checks++;
      if (cond[1] !== 1'b1) $display("FAIL collide_set_wins: got %b want 1", cond[1]);
      else passed++;
      tick(1);
      checks++;
      if (cond[1] !== 1'b0) $display("FAIL collide_next_clr: got %b want 0", cond[1]);
      else passed++;
      clr[1] = 1'b0;
      raw_in[1] = 1'b0;
      tick(LAT + 1);
      checks++;
      if (cond !== 6'b0) $display("FAIL collide_quiet: got %b want 000000", cond);
      else passed++;
   endtask

   task automatic test_timer_a();
      tmr_sel = 1'b0;
      tmr_start = 1'b1;
      tick(1);
      for (int k = 0; k <= 9; k++) begin
         if (k > 0) tick(1);
         checks++;
         if (tmr_busy !== 1'b1 || cond[5] !== 1'b0)
            $display("FAIL timer_a_run E+%0d: got busy=%b done=%b want busy=1 done=0", k, tmr_busy, cond[5]);
         else passed++;
      end
      tick(1);
      checks++;
      if (tmr_busy !== 1'b0 || cond[5] !== 1'b1)
         $display("FAIL timer_a_done: got busy=%b done=%b want busy=0 done=1", tmr_busy, cond[5]);
      else passed++;
      tick(5);
      checks++;
      if (tmr_busy !== 1'b0 || cond[5] !== 1'b1)
         $display("FAIL timer_held_no_restart: got busy=%b done=%b want busy=0 done=1", tmr_busy, cond[5]);
      else passed++;
      tmr_start = 1'b0;
      tick(1);
      checks++;
      if (cond[5] !== 1'b0) $display("FAIL timer_done_clear: got %b want 0", cond[5]);
      else passed++;
   endtask

   task automatic test_timer_abort();
      tmr_start = 1'b1;
      tick(5);
      tmr_start = 1'b0;
      tick(1);
      checks++;
      if (tmr_busy !== 1'b0) $display("FAIL timer_abort_busy: got %b want 0", tmr_busy);
      else passed++;
      tick(10);
      checks++;
      if (cond[5] !== 1'b0) $display("FAIL timer_abort_done: got %b want 0", cond[5]);
      else passed++;
   endtask

   task automatic test_timer_b();
      tmr_sel = 1'b1;
      tmr_start = 1'b1;
      tick(1);
      tmr_sel = 1'b0;
      tick(19);
      checks++;
      if (tmr_busy !== 1'b1 || cond[5] !== 1'b0)
         $display("FAIL timer_b_run: got busy=%b done=%b want busy=1 done=0", tmr_busy, cond[5]);
      else passed++;
      tick(1);
      checks++;
      if (cond[5] !== 1'b1) $display("FAIL timer_b_done: got %b want 1", cond[5]);
      else passed++;
      tmr_start = 1'b0;
      tick(2);
   endtask

   task automatic test_reset_mid();
      raw_in[0] = 1'b1;
      tick(LAT + 1);
      tmr_start = 1'b1;
      tick(3);
      checks++;
      if (cond[0] !== 1'b1 || tmr_busy !== 1'b1)
         $display("FAIL pre_reset: got cond0=%b busy=%b want 1 1", cond[0], tmr_busy);
      else passed++;
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (cond !== 6'b0 || tmr_busy !== 1'b0)
         $display("FAIL async_reset: got cond=%b busy=%b want 000000 0", cond, tmr_busy);
      else passed++;
      tmr_start = 1'b0;
      tick(2);
      rst = 1'b1;
      for (int k = 1; k <= LAT; k++) begin
         tick(1);
         checks++;
         if (cond[0] !== (k >= LAT)) $display("FAIL requalify edge %0d: got %b want %b", k, cond[0], k >= LAT);
         else passed++;
      end
      checks++;
      if (tmr_busy !== 1'b0 || cond[5] !== 1'b0)
         $display("FAIL reset_timer_idle: got busy=%b done=%b want 0 0", tmr_busy, cond[5]);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_level();
      test_glitch();
      test_clr_collision();
      test_timer_a();
      test_timer_abort();
      test_timer_b();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
